// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared helpers and constants for the IIR notch biquad datapath
package iir_pkg;

    // b0x0 + b1x1 + b2x2 - a1y1 - a2y2
    localparam logic [4:0] NOTCH_SUB_MASK = 5'b11000;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Headroom for N_TERMS additions plus one bit so negating the most negative term cannot wrap
    function automatic int acc_width(input int width, input int n_terms);
        return 2 * width + clog2(n_terms) + 1;
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// rtl/iir_round_sat.sv - combinational round-half-up, shift and narrow of the accumulator
// SUM_SATURATE_EN selects clamping with ovf; otherwise the result wraps and ovf_o is 0.
module iir_round_sat #(
    parameter int IN_W      = 68,
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 30
) (
    input  logic signed [IN_W-1:0] sum_i,
    output logic [OUT_W-1:0]       data_o,
    output logic                   ovf_o
);
    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (FRAC_BITS - 1);

    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    // One extra bit so adding the rounding constant cannot wrap
    assign biased  = {sum_i[IN_W-1], sum_i} + HALF;
    assign shifted = biased >>> FRAC_BITS;

`ifdef SUM_SATURATE_EN
    logic [EXT_W-OUT_W:0] upper;
    logic                 in_range;

    assign upper    = shifted[EXT_W-1:OUT_W-1];
    assign in_range = (&upper) || !(|upper);

    always_comb begin
        data_o = shifted[OUT_W-1:0];
        ovf_o  = 1'b0;
        if (!in_range) begin
            ovf_o  = 1'b1;
            data_o = shifted[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^shifted[EXT_W-1:OUT_W];
    assign data_o    = shifted[OUT_W-1:0];
    assign ovf_o     = 1'b0;
`endif

endmodule

// File: rtl/biquad_sum_pipe.sv
// rtl/biquad_sum_pipe.sv - 3-stage signed term summer with rounding and channel tags
// Output saturation is enabled by SUM_SATURATE_EN (inside iir_round_sat).
module biquad_sum_pipe
    import iir_pkg::*;
#(
    parameter int                   WIDTH     = 32,
    parameter int                   N_TERMS   = 5,
    parameter logic [N_TERMS-1:0]   SUB_MASK  = N_TERMS'(NOTCH_SUB_MASK),
    parameter int                   FRAC_BITS = 30,
    parameter int                   OUT_W     = 32,
    parameter int                   CH_W      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CH_W-1:0]            in_chan,
    input  logic [N_TERMS*2*WIDTH-1:0] in_terms,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_W-1:0]            out_chan,
    output logic [OUT_W-1:0]           out_data,
    output logic                       ovf
);
    localparam int TERM_W = 2 * WIDTH;
    localparam int ACC_W  = acc_width(WIDTH, N_TERMS);

    logic                    adv;
    logic signed [ACC_W-1:0] term_d [N_TERMS];
    logic signed [ACC_W-1:0] term_q [N_TERMS];
    logic [CH_W-1:0]         s1_chan_q;
    logic                    s1_valid_q;
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] sum_q;
    logic [CH_W-1:0]         s2_chan_q;
    logic                    s2_valid_q;
    logic [OUT_W-1:0]        rnd_data;
    logic                    rnd_ovf;
    logic [OUT_W-1:0]        out_data_q;
    logic [CH_W-1:0]         out_chan_q;
    logic                    out_valid_q;
    logic                    ovf_q;

    // Whole pipe moves as one; a stalled output freezes every stage
    assign adv      = out_ready || !out_valid_q;
    assign in_ready = adv;

    always_comb begin
        for (int i = 0; i < N_TERMS; i++) begin
            term_d[i] = {{(ACC_W-TERM_W){in_terms[i*TERM_W+TERM_W-1]}},
                         in_terms[i*TERM_W +: TERM_W]};
            if (SUB_MASK[i]) begin
                term_d[i] = -term_d[i];
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_TERMS; i++) begin
            sum_d = sum_d + term_q[i];
        end
    end

    iir_round_sat #(
        .IN_W      (ACC_W),
        .OUT_W     (OUT_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .sum_i  (sum_q),
        .data_o (rnd_data),
        .ovf_o  (rnd_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TERMS; i++) begin
                term_q[i] <= '0;
            end
            s1_chan_q   <= '0;
            s1_valid_q  <= 1'b0;
            sum_q       <= '0;
            s2_chan_q   <= '0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            term_q      <= term_d;
            s1_chan_q   <= in_chan;
            s1_valid_q  <= in_valid;
            sum_q       <= sum_d;
            s2_chan_q   <= s1_chan_q;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            ovf_q       <= s2_valid_q && rnd_ovf;
            // Output data/tag keep the last real beat across bubbles
            if (s2_valid_q) begin
                out_data_q <= rnd_data;
                out_chan_q <= s2_chan_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_biquad_sum_pipe.sv
// tb/tb_biquad_sum_pipe.sv - directed vector bench for biquad_sum_pipe (SUM_SATURATE_EN aware)
module tb_biquad_sum_pipe;
    localparam int WIDTH     = 16;
    localparam int N_TERMS   = 5;
    localparam int FRAC_BITS = 14;
    localparam int OUT_W     = 16;
    localparam int CH_W      = 2;
    localparam int N_VEC     = 13;
`ifdef SUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [4:0][31:0] t;
        logic [1:0]       chan;
        logic [15:0]      wrap;
        logic [15:0]      sat;
        logic             sat_ovf;
    } vec_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [1:0]   in_chan   = '0;
    logic [159:0] in_terms  = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [1:0]   out_chan;
    logic [15:0]  out_data;
    logic         ovf;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [N_VEC];

    biquad_sum_pipe #(
        .WIDTH     (WIDTH),
        .N_TERMS   (N_TERMS),
        .SUB_MASK  (5'b11000),
        .FRAC_BITS (FRAC_BITS),
        .OUT_W     (OUT_W),
        .CH_W      (CH_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_chan   (in_chan),
        .in_terms  (in_terms),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_data  (out_data),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] t0, input logic [31:0] t1,
                                input logic [31:0] t2, input logic [31:0] t3,
                                input logic [31:0] t4, input logic [1:0] ch,
                                input logic [15:0] w, input logic [15:0] s,
                                input logic so);
        vec_t v;
        v.t       = {t4, t3, t2, t1, t0};
        v.chan    = ch;
        v.wrap    = w;
        v.sat     = s;
        v.sat_ovf = so;
        return v;
    endfunction

    // One beat into an idle pipe: must appear exactly after the third edge
    task automatic send_and_check(input string name, input logic [159:0] terms,
                                  input logic [1:0] ch, input logic [15:0] exp_data,
                                  input logic exp_ovf);
        in_valid = 1'b1;
        in_terms = terms;
        in_chan  = ch;
        #1;
        chk({name, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_terms = '0;
        chk({name, "_lat1"}, out_valid, 0);
        @(negedge clk);
        chk({name, "_lat2"}, out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_data"}, out_data, exp_data);
        chk({name, "_chan"}, out_chan, ch);
        chk({name, "_ovf"}, ovf, exp_ovf);
    endtask

    initial begin
        int sent;
        int rcvd;
        int stall_seen;
        int stale;

        vecs[0]  = mk(32'h4000, 32'h8000, 32'hC000, 32'h10000, 32'h14000, 2'd2, 16'hFFFD, 16'hFFFD, 1'b0);
        vecs[1]  = mk(32'h2000, 0, 0, 0, 0, 2'd1, 16'h0001, 16'h0001, 1'b0);
        vecs[2]  = mk(0, 0, 0, 32'h2000, 0, 2'd3, 16'h0000, 16'h0000, 1'b0);
        vecs[3]  = mk(32'h1FFF, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 1'b0);
        vecs[4]  = mk(0, 0, 0, 32'h2001, 0, 2'd1, 16'hFFFF, 16'hFFFF, 1'b0);
        vecs[5]  = mk(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 0, 0, 2'd3, 16'h0000, 16'h7FFF, 1'b1);
        vecs[6]  = mk(0, 0, 0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 2'd0, 16'h0000, 16'h8000, 1'b1);
        vecs[7]  = mk(32'h1FFF_E000, 0, 0, 0, 0, 2'd2, 16'h8000, 16'h7FFF, 1'b1);
        vecs[8]  = mk(32'h1FFF_C000, 0, 0, 0, 0, 2'd1, 16'h7FFF, 16'h7FFF, 1'b0);
        vecs[9]  = mk(0, 0, 0, 32'h2000_0000, 0, 2'd0, 16'h8000, 16'h8000, 1'b0);
        vecs[10] = mk(0, 0, 0, 32'h2000_2001, 0, 2'd3, 16'h7FFF, 16'h8000, 1'b1);
        vecs[11] = mk(0, 0, 0, 0, 0, 2'd1, 16'h0000, 16'h0000, 1'b0);
        vecs[12] = mk(32'hFFFF_C000, 0, 0, 32'hFFFF_8000, 0, 2'd2, 16'h0001, 16'h0001, 1'b0);

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_chan", out_chan, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < N_VEC; k++) begin
            send_and_check($sformatf("vec%0d", k), vecs[k].t, vecs[k].chan,
                           SAT ? vecs[k].sat : vecs[k].wrap, SAT & vecs[k].sat_ovf);
        end
        @(negedge clk);

        // 8 back-to-back beats with a 4-cycle downstream stall
        sent       = 0;
        rcvd       = 0;
        stall_seen = 0;
        for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
            out_ready       = !(cyc >= 5 && cyc < 9);
            in_valid        = (sent < 8);
            in_terms        = '0;
            in_terms[31:0]  = 32'(sent + 1) << 14;
            in_chan         = sent[1:0];
            #1;
            if (out_valid) begin
                chk($sformatf("stall_data%0d", rcvd), out_data, 32'(rcvd + 1));
                chk($sformatf("stall_chan%0d", rcvd), out_chan, 32'(rcvd % 4));
                if (!out_ready) begin
                    chk("stall_in_ready", in_ready, 0);
                    stall_seen++;
                end else begin
                    rcvd++;
                end
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        chk("stall_all_received", rcvd, 8);
        chk("stall_cycles_seen", stall_seen, 4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("stall_drained", out_valid, 0);

        // Reset with three beats in flight
        for (int k = 0; k < 3; k++) begin
            in_valid       = 1'b1;
            in_terms       = '0;
            in_terms[31:0] = 32'(k + 7) << 14;
            in_chan        = 2'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) stale++;
            @(negedge clk);
        end
        chk("post_rst_no_stale", stale, 0);
        send_and_check("post_rst", {128'd0, 32'h0002_4000}, 2'd3, 16'h0009, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
